uart_rx_msg: RTL
================

Name: uart_rx_msg

Overview:
Serial UART receiver for the wireless link, the downstream counterpart of the message-register/UART-transmit path. It deserialises 8N1 frames from the radio RX line into bytes. It holds each received byte in a one-entry output buffer with a valid/ack handshake, which feeds the game-logic message register. It also flags framing errors and overruns.

Parameters:
CLKS_PER_BIT, 1042, clock cycles per UART bit (C); must be >= 4
SYNC_STAGES, 2, input synchroniser depth (fixed at 2 for this revision)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
rx_serial  input  1  asynchronous serial line, idle high
ack  input  1  consumer has taken rx_byte; honoured only while rx_valid=1
rx_byte  output  8  last accepted byte, LSB received first
rx_valid  output  1  rx_byte holds an unconsumed byte (level)
framing_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: a good frame arrived while rx_valid=1 without ack
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, active-high): state=IDLE, counters=0, sync flops=1, rx_byte=8'h00, rx_valid=0, framing_err=0, overrun=0, busy=0. Reset mid-frame abandons the frame with no output pulse.
- rx_serial passes through a 2-flop synchroniser; the FSM only sees the synchronised signal s.
- H = (C-1)/2, using integer division.
- FSM states and transitions:
  - IDLE: when s=0, go to START with cnt=0.
  - START: cnt increments each cycle. When cnt==H, sample s.
    - s=0: go to DATA with cnt=0, idx=0.
    - s=1: treat as a glitch and return to IDLE with no flags.
  - DATA: when cnt==C-1, shift s into shreg[idx], reset cnt to 0 and increment idx. After idx 7 is stored, go to STOP.
  - STOP: when cnt==C-1, sample s.
    - s=1: deliver the byte, then go to IDLE.
    - s=0: pulse framing_err for one cycle, discard the byte, go to BREAK.
  - BREAK: wait for s=1, then go to IDLE. A held-low line yields exactly one framing_err.
- Delivery, on the stop-sample edge:
  - If rx_valid=0, or ack=1 in the same cycle: rx_byte<=shreg and rx_valid<=1.
  - Otherwise: rx_byte and rx_valid are unchanged, overrun<=1, and the new byte is dropped.
- Handshake:
  - ack with rx_valid=1 clears rx_valid and overrun on the next edge.
  - ack with rx_valid=0 is ignored.
  - Delivery has priority over clearing: a simultaneous delivery and ack leaves rx_valid=1 with the new byte and clears overrun.
- Latency: let the first low sample of rx_serial be taken at edge k. IDLE->START occurs at k+2, and rx_valid rises at edge k+3+H+9C.
- Counters are sized to clog2(C); idx is 3 bits. There is no wrap condition, because cnt always resets at its terminal count.
- Back-to-back frames: a new start bit is accepted on the first IDLE cycle after STOP; no extra idle time is required.

Test Plan:
1. Reset, then send 0xAB at C=16 with ack held 0 -> rx_valid rises exactly at k+3+7+144; rx_byte=8'hAB; framing_err=0; overrun=0; busy falls on the same edge.
2. Send 0xAB, then 0x6D back-to-back, asserting ack one cycle after each rx_valid -> two deliveries in order, 0xAB then 0x6D; overrun stays 0; rx_valid is high for exactly 1 cycle each.
3. Send 0xAB, no ack, then send 0x6D -> rx_byte stays 0xAB and overrun=1. A later ack clears both rx_valid and overrun.
4. Frame with stop bit driven low, then line held low for 3 bit times -> exactly one framing_err pulse; rx_valid stays 0. After the line returns high, a 0x55 frame is received correctly.
5. Low glitch of 3 cycles on the idle line (shorter than H) -> FSM returns to IDLE; no rx_valid, no flags, busy high for at most H+3 cycles.
6. rst asserted during DATA bit 4 of a frame, released 2 cycles later, then 0x01 sent -> all outputs at reset values; only 0x01 is delivered; no framing_err from the aborted frame.

Source files
------------

// File: rtl/uart_rx_msg.sv
// rtl/uart_rx_msg.sv - 8N1 UART receiver with one-entry valid/ack output buffer
//
// Deserialises 8N1 frames from an asynchronous, idle-high serial line into bytes.
// Each accepted byte is held in a one-entry buffer until the consumer acks it.
// Stop-bit errors and dropped bytes are flagged.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   SYNC_STAGES   depth of the rx_serial synchroniser (2)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_serial    asynchronous serial input, idle high
//   ack          consumer has taken rx_byte (ignored while rx_valid=0)
//   rx_byte      last accepted byte, LSB received first
//   rx_valid     rx_byte holds an unconsumed byte
//   framing_err  one-cycle pulse when a stop bit is sampled low
//   overrun      sticky: a good frame was dropped because the buffer was full
//   busy         receiver is not idle
module uart_rx_msg #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    input  logic       ack,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    // Start bit is checked half a bit in; data and stop bits a full bit after that,
    // so every later sample also lands mid-bit.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   framing_err_q, framing_err_d;
    logic                   overrun_q, overrun_d;
    logic                   deliver;
    logic                   s;

    // Only the synchronised copy of the line is ever looked at.
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], rx_serial};
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shreg_d       = shreg_q;
        rx_byte_d     = rx_byte_q;
        rx_valid_d    = rx_valid_q;
        overrun_d     = overrun_q;
        framing_err_d = 1'b0;
        deliver       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!s) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        // Line back high mid start bit: a glitch, not a frame.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s) begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        framing_err_d = 1'b1;
                        state_d       = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // Hold here while the line stays low so a long break
                // yields a single framing error.
                if (s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Output buffer: a delivery wins over an ack in the same cycle;
        // an ack on a full buffer always clears overrun.
        if (deliver) begin
            if (!rx_valid_q || ack) begin
                rx_byte_d  = shreg_q;
                rx_valid_d = 1'b1;
                if (ack && rx_valid_q) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            shreg_q       <= 8'h00;
            sync_q        <= '1;
            rx_byte_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shreg_q       <= shreg_d;
            sync_q        <= sync_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
